// File: rtl/decoder_scan_sequencer_if.sv
// Control/select bundle between a scan controller and decoder_scan_sequencer.
// master drives the run requests; slave returns decoder select/enable and status.
interface decoder_scan_sequencer_if;
  logic       start;
  logic       stop;
  logic       cont;
  logic [7:0] mask;
  logic [2:0] sel;
  logic       en;
  logic       busy;
  logic       sweep_done;

  modport master (
    output start, stop, cont, mask,
    input  sel, en, busy, sweep_done
  );

  modport slave (
    input  start, stop, cont, mask,
    output sel, en, busy, sweep_done
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Drives a 3-to-8 decoder's select/enable, dwelling DWELL cycles on each unmasked line in
// ascending order. Optional feature macro SCAN_GAP_EN inserts GAP blank cycles between channels.
module decoder_scan_sequencer #(
  parameter int unsigned DWELL = 4
`ifdef SCAN_GAP_EN
  , parameter int unsigned GAP = 1
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  decoder_scan_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CH_W  = 3;
  localparam int unsigned N_CH  = 8;
  localparam int unsigned PICK_W = CH_W + 1;
`ifdef SCAN_GAP_EN
  localparam int unsigned GAP_W = 4;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DWELL_S = 2'd1,
`ifdef SCAN_GAP_EN
    GAP_S   = 2'd2,
`endif
    DONE_S  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  dwell_cnt;
  logic [N_CH-1:0]   mask_q;
  logic              cont_q;
`ifdef SCAN_GAP_EN
  logic [GAP_W-1:0]  gap_cnt;
  logic [CH_W-1:0]   next_sel;
`endif

  logic [PICK_W-1:0] above_c;
  logic [PICK_W-1:0] lowest_c;
  logic [PICK_W-1:0] start_pick_c;
  logic [CH_W-1:0]   adv_ch_c;
  logic              adv_wrap_c;
  logic              dwell_last_c;

  // Lowest set bit of m at index >= lo; MSB of the result flags that one was found.
  function automatic logic [PICK_W-1:0] find_from(input logic [N_CH-1:0] m,
                                                  input logic [PICK_W-1:0] lo);
    logic [PICK_W-1:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (PICK_W'(i) >= lo)) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    above_c      = find_from(mask_q, {1'b0, bus.sel} + PICK_W'(1));
    lowest_c     = find_from(mask_q, '0);
    start_pick_c = find_from(bus.mask, '0);
    adv_wrap_c   = !above_c[CH_W];
    adv_ch_c     = above_c[CH_W] ? above_c[CH_W-1:0] : lowest_c[CH_W-1:0];
    dwell_last_c = (dwell_cnt == CNT_W'(DWELL - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dwell_cnt      <= '0;
      mask_q         <= '0;
      cont_q         <= 1'b0;
      bus.sel        <= '0;
      bus.en         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.sweep_done <= 1'b0;
`ifdef SCAN_GAP_EN
      gap_cnt        <= '0;
      next_sel       <= '0;
`endif
    end else begin
      bus.sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop && start_pick_c[CH_W]) begin
            mask_q    <= bus.mask;
            cont_q    <= bus.cont;
            bus.sel   <= start_pick_c[CH_W-1:0];
            bus.en    <= 1'b1;
            bus.busy  <= 1'b1;
            dwell_cnt <= '0;
            state     <= DWELL_S;
          end
        end

        DWELL_S: begin
          if (bus.stop) begin
            bus.en   <= 1'b0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (!dwell_last_c) begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
          end else if (above_c[CH_W] || cont_q) begin
            // Move to the next channel; a wrap back to the lowest one marks a finished sweep.
            bus.sweep_done <= adv_wrap_c;
`ifdef SCAN_GAP_EN
            next_sel <= adv_ch_c;
            gap_cnt  <= '0;
            bus.en   <= 1'b0;
            state    <= GAP_S;
`else
            bus.sel   <= adv_ch_c;
            dwell_cnt <= '0;
`endif
          end else begin
            bus.en         <= 1'b0;
            bus.sweep_done <= 1'b1;
            state          <= DONE_S;
          end
        end

`ifdef SCAN_GAP_EN
        GAP_S: begin
          if (bus.stop) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (gap_cnt == GAP_W'(GAP - 1)) begin
            bus.sel   <= next_sel;
            bus.en    <= 1'b1;
            dwell_cnt <= '0;
            state     <= DWELL_S;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
`endif

        DONE_S: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.en   <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
